// File: rtl/commit_snapshot_ctrl.sv
// Buffers retired-instruction commit records in a small FIFO and presents one
// architectural snapshot (next PC plus full shadow GPR file) per record to a sink.
module commit_snapshot_ctrl #(
    parameter int NR_REGS = 16,
    parameter int DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  commit_valid,
    output logic                  commit_ready,
    input  logic [31:0]           commit_npc,
    input  logic                  commit_wen,
    input  logic [4:0]            commit_rd,
    input  logic [31:0]           commit_wdata,
    output logic                  snap_valid,
    input  logic                  snap_ready,
    output logic [31:0]           snap_npc,
    output logic [NR_REGS*32-1:0] snap_gprs,
    output logic [31:0]           snap_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    state_t state_reg, state_next;

    logic [31:0]   fifo_npc   [DEPTH];
    logic          fifo_wen   [DEPTH];
    logic [4:0]    fifo_rd    [DEPTH];
    logic [31:0]   fifo_wdata [DEPTH];

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [31:0]   snap_npc_reg;
    logic [31:0]   snap_count_reg;

    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          snap_hs;
    logic [31:0]   head_npc;
    logic          head_wen;
    logic [4:0]    head_rd;
    logic [31:0]   head_wdata;

    assign fifo_empty   = (count_reg == '0);
    assign fifo_full    = (count_reg == (AW+1)'(DEPTH));
    // Full is judged on the current occupancy only, so a pop never frees a slot in the same cycle.
    assign commit_ready = resetn & ~fifo_full & ~flush;
    assign push         = commit_valid & commit_ready;
    assign snap_hs      = (state_reg == PRESENT) & snap_ready;

    assign head_npc   = fifo_npc[rd_ptr_reg];
    assign head_wen   = fifo_wen[rd_ptr_reg];
    assign head_rd    = fifo_rd[rd_ptr_reg];
    assign head_wdata = fifo_wdata[rd_ptr_reg];

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = PRESENT;
                    end
                end
                PRESENT: begin
                    if (snap_ready) begin
                        if (!fifo_empty) begin
                            pop = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Record storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_npc[wr_ptr_reg]   <= commit_npc;
            fifo_wen[wr_ptr_reg]   <= commit_wen;
            fifo_rd[wr_ptr_reg]    <= commit_rd;
            fifo_wdata[wr_ptr_reg] <= commit_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            snap_npc_reg   <= '0;
            snap_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
                if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
                count_reg <= count_reg + (AW+1)'(push) - (AW+1)'(pop);
            end
            if (pop) snap_npc_reg <= head_npc;
            if (snap_hs) snap_count_reg <= snap_count_reg + 32'd1;
        end
    end

    // Shadow GPR file: x0 is hardwired to zero, out-of-range rd never matches any slot.
    generate
        for (genvar gi = 0; gi < NR_REGS; gi++) begin : g_gpr
            if (gi == 0) begin : g_zero
                assign snap_gprs[31:0] = 32'd0;
            end else begin : g_reg
                logic [31:0] gpr_reg;
                always_ff @(posedge clk) begin
                    if (!resetn) begin
                        gpr_reg <= '0;
                    end else if (pop && head_wen && (head_rd == 5'(gi))) begin
                        gpr_reg <= head_wdata;
                    end
                end
                assign snap_gprs[gi*32 +: 32] = gpr_reg;
            end
        end
    endgenerate

    assign snap_valid = (state_reg == PRESENT);
    assign snap_npc   = snap_npc_reg;
    assign snap_count = snap_count_reg;

endmodule

// File: tb/tb_commit_snapshot_ctrl.sv
// Self-checking bench for commit_snapshot_ctrl: directed scenarios plus a randomized
// run scored against a record-queue model of the architectural state.
module tb_commit_snapshot_ctrl;

    localparam int NR = 16;
    localparam int DP = 4;

    typedef struct packed {
        logic [31:0] npc;
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] wdata;
    } rec_t;

    logic             clk = 1'b0;
    logic             resetn;
    logic             flush;
    logic             commit_valid;
    logic             commit_ready;
    logic [31:0]      commit_npc;
    logic             commit_wen;
    logic [4:0]       commit_rd;
    logic [31:0]      commit_wdata;
    logic             snap_valid;
    logic             snap_ready;
    logic [31:0]      snap_npc;
    logic [NR*32-1:0] snap_gprs;
    logic [31:0]      snap_count;

    int checks = 0;
    int errors = 0;

    logic [NR*32-1:0] model_g;
    logic [31:0]      model_cnt;
    rec_t             idle_rec;

    commit_snapshot_ctrl #(.NR_REGS(NR), .DEPTH(DP)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .flush        (flush),
        .commit_valid (commit_valid),
        .commit_ready (commit_ready),
        .commit_npc   (commit_npc),
        .commit_wen   (commit_wen),
        .commit_rd    (commit_rd),
        .commit_wdata (commit_wdata),
        .snap_valid   (snap_valid),
        .snap_ready   (snap_ready),
        .snap_npc     (snap_npc),
        .snap_gprs    (snap_gprs),
        .snap_count   (snap_count)
    );

    always #5 clk = ~clk;

    function automatic rec_t mk(input logic [31:0] npc, input logic wen,
                                input logic [4:0] rd, input logic [31:0] wd);
        rec_t r;
        r.npc = npc; r.wen = wen; r.rd = rd; r.wdata = wd;
        return r;
    endfunction

    // Architectural effect of retiring one record.
    function automatic logic [NR*32-1:0] apply_rec(input logic [NR*32-1:0] g, input rec_t r);
        logic [NR*32-1:0] t;
        t = g;
        if (r.wen && r.rd != 5'd0 && int'(r.rd) < NR) t[int'(r.rd)*32 +: 32] = r.wdata;
        return t;
    endfunction

    // Drive inputs on the falling edge, then let combinational outputs settle.
    task automatic drive(input logic cv, input rec_t r, input logic sr,
                         input logic fl, input logic rn);
        @(negedge clk);
        commit_valid = cv;
        commit_npc   = r.npc;
        commit_wen   = r.wen;
        commit_rd    = r.rd;
        commit_wdata = r.wdata;
        snap_ready   = sr;
        flush        = fl;
        resetn       = rn;
        #1;
    endtask

    task automatic test_reset;
        drive(1'b1, mk(32'h1234, 1'b1, 5'd3, 32'h55), 1'b1, 1'b0, 1'b0);
        drive(1'b1, mk(32'h1234, 1'b1, 5'd3, 32'h55), 1'b1, 1'b0, 1'b0);
        checks++;
        if (commit_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", commit_ready); end
        checks++;
        if (snap_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", snap_valid); end
        checks++;
        if (snap_count !== 32'd0) begin errors++; $display("FAIL reset_count got %h want 0", snap_count); end
        checks++;
        if (snap_npc !== 32'd0) begin errors++; $display("FAIL reset_npc got %h want 0", snap_npc); end
        checks++;
        if (snap_gprs !== '0) begin errors++; $display("FAIL reset_gprs got %h want 0", snap_gprs); end
        model_g   = '0;
        model_cnt = 32'd0;
    endtask

    task automatic test_single;
        rec_t r;
        logic [NR*32-1:0] eg;
        r  = mk(32'h8000_0004, 1'b1, 5'd5, 32'hDEAD_BEEF);
        eg = apply_rec(model_g, r);
        drive(1'b1, r, 1'b1, 1'b0, 1'b1);
        checks++;
        if (commit_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", commit_ready); end
        drive(1'b0, idle_rec, 1'b1, 1'b0, 1'b1);
        checks++;
        if (snap_valid !== 1'b0) begin errors++; $display("FAIL single_t1_valid got %b want 0", snap_valid); end
        drive(1'b0, idle_rec, 1'b1, 1'b0, 1'b1);
        checks++;
        if (snap_valid !== 1'b1) begin errors++; $display("FAIL single_t2_valid got %b want 1", snap_valid); end
        checks++;
        if (snap_npc !== 32'h8000_0004) begin errors++; $display("FAIL single_npc got %h want 80000004", snap_npc); end
        checks++;
        if (snap_gprs !== eg) begin errors++; $display("FAIL single_gprs got %h want %h", snap_gprs, eg); end
        $display("snap npc=%h gpr5=%h", snap_npc, snap_gprs[5*32 +: 32]);
        drive(1'b0, idle_rec, 1'b1, 1'b0, 1'b1);
        checks++;
        if (snap_count !== 32'd1) begin errors++; $display("FAIL single_count got %h want 1", snap_count); end
        checks++;
        if (snap_valid !== 1'b0) begin errors++; $display("FAIL single_after_valid got %b want 0", snap_valid); end
        model_g   = eg;
        model_cnt = 32'd1;
    endtask

    task automatic test_x0_oob;
        rec_t rs [2];
        int   k;
        rs[0] = mk(32'h8000_0008, 1'b1, 5'd0,  32'h1);
        rs[1] = mk(32'h8000_000C, 1'b1, 5'd20, 32'h1);
        k = 0;
        for (int i = 0; i < 10; i++) begin
            drive(i < 2, (i < 2) ? rs[i] : idle_rec, 1'b1, 1'b0, 1'b1);
            if (snap_valid && k < 2) begin
                checks++;
                if (snap_npc !== rs[k].npc) begin errors++; $display("FAIL x0oob_npc%0d got %h want %h", k, snap_npc, rs[k].npc); end
                checks++;
                if (snap_gprs !== model_g) begin errors++; $display("FAIL x0oob_gprs%0d got %h want %h", k, snap_gprs, model_g); end
                $display("snap npc=%h gpr0=%h", snap_npc, snap_gprs[31:0]);
                k++;
            end
        end
        checks++;
        if (k !== 2) begin errors++; $display("FAIL x0oob_snaps got %0d want 2", k); end
        model_cnt = model_cnt + 32'd2;
        checks++;
        if (snap_count !== model_cnt) begin errors++; $display("FAIL x0oob_count got %h want %h", snap_count, model_cnt); end
    endtask

    task automatic test_backpressure;
        rec_t             rs [6];
        logic [NR*32-1:0] eg [5];
        logic [NR*32-1:0] g;
        for (int i = 0; i < 6; i++)
            rs[i] = mk(32'h9000_0000 + 32'(4 * i), 1'b1, 5'(i + 1), $urandom);
        g = model_g;
        for (int i = 0; i < 5; i++) begin
            g = apply_rec(g, rs[i]);
            eg[i] = g;
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, rs[i], 1'b0, 1'b0, 1'b1);
            checks++;
            if (commit_ready !== (i < 5)) begin errors++; $display("FAIL bp_ready%0d got %b want %b", i, commit_ready, (i < 5)); end
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, idle_rec, 1'b1, 1'b0, 1'b1);
            checks++;
            if (snap_valid !== 1'b1) begin errors++; $display("FAIL bp_valid%0d got %b want 1", i, snap_valid); end
            checks++;
            if (snap_npc !== rs[i].npc) begin errors++; $display("FAIL bp_npc%0d got %h want %h", i, snap_npc, rs[i].npc); end
            checks++;
            if (snap_gprs !== eg[i]) begin errors++; $display("FAIL bp_gprs%0d got %h want %h", i, snap_gprs, eg[i]); end
            $display("snap npc=%h", snap_npc);
        end
        drive(1'b0, idle_rec, 1'b1, 1'b0, 1'b1);
        model_cnt = model_cnt + 32'd5;
        model_g   = eg[4];
        checks++;
        if (snap_valid !== 1'b0) begin errors++; $display("FAIL bp_drained_valid got %b want 0", snap_valid); end
        checks++;
        if (snap_count !== model_cnt) begin errors++; $display("FAIL bp_count got %h want %h", snap_count, model_cnt); end
    endtask

    task automatic test_flush;
        rec_t             rs [4];
        logic [NR*32-1:0] eg;
        logic             seen;
        for (int i = 0; i < 4; i++)
            rs[i] = mk(32'hA000_0000 + 32'(4 * i), 1'b1, 5'(i + 7), $urandom);
        eg = apply_rec(model_g, rs[0]);
        for (int i = 0; i < 4; i++) drive(1'b1, rs[i], 1'b0, 1'b0, 1'b1);
        drive(1'b1, rs[0], 1'b0, 1'b1, 1'b1);
        checks++;
        if (commit_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", commit_ready); end
        drive(1'b0, idle_rec, 1'b1, 1'b0, 1'b1);
        checks++;
        if (snap_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", snap_valid); end
        checks++;
        if (snap_npc !== rs[0].npc) begin errors++; $display("FAIL flush_npc got %h want %h", snap_npc, rs[0].npc); end
        checks++;
        if (snap_gprs !== eg) begin errors++; $display("FAIL flush_gprs got %h want %h", snap_gprs, eg); end
        checks++;
        if (snap_count !== model_cnt) begin errors++; $display("FAIL flush_count got %h want %h", snap_count, model_cnt); end
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, idle_rec, 1'b1, 1'b0, 1'b1);
            if (snap_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL flush_stale got %b want 0", seen); end
        $display("flush done npc=%h count=%h", snap_npc, snap_count);
        model_g = eg;
    endtask

    task automatic test_reset_mid;
        logic seen;
        for (int i = 0; i < 3; i++)
            drive(1'b1, mk(32'hB000_0000 + 32'(4 * i), 1'b1, 5'(i + 2), $urandom), 1'b0, 1'b0, 1'b1);
        drive(1'b1, mk(32'hB000_0100, 1'b1, 5'd9, 32'h77), 1'b1, 1'b1, 1'b0);
        drive(1'b0, idle_rec, 1'b1, 1'b0, 1'b1);
        checks++;
        if (snap_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", snap_valid); end
        checks++;
        if (snap_count !== 32'd0) begin errors++; $display("FAIL rstmid_count got %h want 0", snap_count); end
        checks++;
        if (snap_gprs !== '0) begin errors++; $display("FAIL rstmid_gprs got %h want 0", snap_gprs); end
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, idle_rec, 1'b1, 1'b0, 1'b1);
            if (snap_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_stale got %b want 0", seen); end
        $display("reset mid-operation done count=%h", snap_count);
        model_g   = '0;
        model_cnt = 32'd0;
    endtask

    task automatic test_wrap;
        rec_t        rs [2];
        logic [31:0] exp_cnt [2];
        int          k;
        logic        prev_hs;
        rs[0] = mk(32'hC000_0000, 1'b1, 5'd1, 32'h1111_1111);
        rs[1] = mk(32'hC000_0004, 1'b1, 5'd2, 32'h2222_2222);
        exp_cnt[0] = 32'h0000_0000;
        exp_cnt[1] = 32'h0000_0001;
        @(negedge clk);
        force dut.snap_count_reg = 32'hFFFF_FFFF;
        #1;
        release dut.snap_count_reg;
        k = 0;
        prev_hs = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(i < 2, (i < 2) ? rs[i] : idle_rec, 1'b1, 1'b0, 1'b1);
            if (prev_hs) begin
                checks++;
                if (snap_count !== exp_cnt[k - 1]) begin errors++; $display("FAIL wrap_count%0d got %h want %h", k - 1, snap_count, exp_cnt[k - 1]); end
            end
            prev_hs = 1'b0;
            if (snap_valid && k < 2) begin
                model_g = apply_rec(model_g, rs[k]);
                checks++;
                if (snap_gprs !== model_g) begin errors++; $display("FAIL wrap_gprs%0d got %h want %h", k, snap_gprs, model_g); end
                $display("snap npc=%h", snap_npc);
                prev_hs = 1'b1;
                k++;
            end
        end
        checks++;
        if (k !== 2) begin errors++; $display("FAIL wrap_snaps got %0d want 2", k); end
        model_cnt = 32'd1;
    endtask

    task automatic test_random;
        rec_t             pend [$];
        rec_t             r;
        logic             cv, sr, fl, exp_ready;
        logic [NR*32-1:0] g;
        int               occ;
        for (int i = 0; i < 420; i++) begin
            if (i < 400) begin
                cv = ($urandom_range(0, 1) == 1);
                sr = ($urandom_range(0, 3) != 0);
                fl = ($urandom_range(0, 39) == 0);
            end else begin
                cv = 1'b0; sr = 1'b1; fl = 1'b0;
            end
            r = mk($urandom, ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom);
            drive(cv, r, sr, fl, 1'b1);
            occ = pend.size() - (snap_valid ? 1 : 0);
            exp_ready = !fl && (occ < DP);
            checks++;
            if (commit_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready cyc%0d got %b want %b", i, commit_ready, exp_ready); end
            checks++;
            if (snap_count !== model_cnt) begin errors++; $display("FAIL rnd_count cyc%0d got %h want %h", i, snap_count, model_cnt); end
            if (snap_valid) begin
                checks++;
                if (pend.size() == 0) begin
                    errors++; $display("FAIL rnd_phantom cyc%0d got valid=1 want 0", i);
                end else begin
                    g = apply_rec(model_g, pend[0]);
                    if (snap_npc !== pend[0].npc || snap_gprs !== g) begin
                        errors++;
                        $display("FAIL rnd_snap cyc%0d got npc=%h want npc=%h gprs got %h want %h", i, snap_npc, pend[0].npc, snap_gprs, g);
                    end
                    if (sr) begin
                        $display("snap npc=%h count=%h", snap_npc, model_cnt);
                        model_g = g;
                        void'(pend.pop_front());
                        model_cnt = model_cnt + 32'd1;
                    end else if (fl) begin
                        model_g = g;
                    end
                end
            end
            if (fl) pend.delete();
            else if (cv && exp_ready) pend.push_back(r);
        end
        checks++;
        if (pend.size() != 0 || snap_valid !== 1'b0) begin
            errors++; $display("FAIL rnd_drain got pending=%0d valid=%b want 0 0", pend.size(), snap_valid);
        end
    endtask

    initial begin
        idle_rec     = mk(32'd0, 1'b0, 5'd0, 32'd0);
        resetn       = 1'b0;
        flush        = 1'b0;
        commit_valid = 1'b0;
        commit_npc   = '0;
        commit_wen   = 1'b0;
        commit_rd    = '0;
        commit_wdata = '0;
        snap_ready   = 1'b0;
        model_g      = '0;
        model_cnt    = '0;
        test_reset();
        test_single();
        test_x0_oob();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/commit_snapshot_ctrl.md
COMMIT_SNAPSHOT_CTRL -- requirements
Module: commit_snapshot_ctrl

Interface
REQ-001 The block SHALL have parameter NR_REGS, default 16, the number of architectural GPRs tracked (legal values 16 or 32).
REQ-002 The block SHALL have parameter DEPTH, default 4, the commit FIFO depth (power of two, at least 2).
REQ-003 The block SHALL have port clk, input, 1 bit, the system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1 bit, the reset: synchronous, active-low.
REQ-005 The block SHALL have port flush, input, 1 bit, a synchronous discard of all pending commit records.
REQ-006 The block SHALL have port commit_valid, input, 1 bit, which marks a retired instruction record on the commit_* inputs.
REQ-007 The block SHALL have port commit_ready, output, 1 bit, which is high when the block can accept a record.
REQ-008 The block SHALL have port commit_npc, input, 32 bits, the next PC after the retired instruction.
REQ-009 The block SHALL have port commit_wen, input, 1 bit, which is high when the retired instruction writes a GPR.
REQ-010 The block SHALL have port commit_rd, input, 5 bits, the destination GPR index.
REQ-011 The block SHALL have port commit_wdata, input, 32 bits, the destination write data.
REQ-012 The block SHALL have port snap_valid, output, 1 bit, which marks a valid architectural snapshot on the snap_* outputs.
REQ-013 The block SHALL have port snap_ready, input, 1 bit, the sink (simulator state-export) acceptance signal.
REQ-014 The block SHALL have port snap_npc, output, 32 bits, the snapshot next PC.
REQ-015 The block SHALL have port snap_gprs, output, NR_REGS*32 bits, the snapshot GPRs; register i occupies bits [i*32+31 : i*32].
REQ-016 The block SHALL have port snap_count, output, 32 bits, the number of snapshots accepted by the sink.

Function
REQ-017 A commit handshake SHALL occur in a cycle with commit_valid, commit_ready and no flush; the record {npc, wen, rd, wdata} is pushed into the FIFO.
REQ-018 commit_ready SHALL equal (FIFO not full) AND NOT flush, with no same-cycle push-when-full even if a pop occurs.
REQ-019 The block SHALL keep a shadow GPR file of NR_REGS x 32 bits, updated only when a record is popped.
REQ-020 On a pop with wen=1, rd!=0 and rd<NR_REGS, the shadow register rd SHALL take wdata; otherwise the shadow file is unchanged.
REQ-021 Shadow register 0 SHALL always read zero.
REQ-022 The FSM SHALL have exactly two states: IDLE and PRESENT.
REQ-023 In IDLE with the FIFO non-empty, the block SHALL pop the head, apply it to the shadow file, latch its npc into snap_npc, and go to PRESENT.
REQ-024 In PRESENT, snap_valid SHALL be 1, and snap_npc and snap_gprs SHALL be held stable until snap_ready.
REQ-025 In PRESENT, on snap_ready with the FIFO non-empty, the block SHALL pop and apply the next record in the same cycle and stay in PRESENT (throughput of one snapshot per cycle).
REQ-026 In PRESENT, on snap_ready with the FIFO empty, the block SHALL go to IDLE.
REQ-027 The minimum latency SHALL be 2 cycles: a record accepted in cycle t appears with snap_valid=1 in cycle t+2 when the FIFO was empty and the state was IDLE. There is no bypass path.
REQ-028 snap_gprs SHALL be the registered shadow file and reflect all records up to and including the presented one.
REQ-029 snap_count SHALL increment by 1 on every snap_valid AND snap_ready cycle, wrapping from 0xFFFFFFFF to 0.
REQ-030 On flush, the FIFO SHALL empty, the state SHALL go to IDLE, and snap_valid SHALL be 0 from the next cycle.
REQ-031 On flush, the shadow file, snap_npc and snap_count SHALL be preserved.
REQ-032 A snapshot handshake in the same cycle as flush SHALL still count.
REQ-033 FIFO pointers SHALL wrap modulo DEPTH, with separate full and empty determination (an occupancy counter of width log2(DEPTH)+1).

Reset
REQ-034 When resetn=0 at a clock edge, the block SHALL clear the FIFO, set the state to IDLE, and clear snap_valid, snap_npc, snap_gprs, snap_count and all shadow registers to 0.
REQ-035 resetn=0 SHALL override flush and any handshake in that cycle.
REQ-036 commit_ready SHALL be 0 while resetn=0.

Verification
REQ-037 The bench SHALL cover single commit: after reset, one commit {npc=0x80000004, wen=1, rd=5, wdata=0xDEADBEEF} with snap_ready=1 -> snap_valid=1 two cycles later, snap_npc=0x80000004, gpr5=0xDEADBEEF, other GPRs 0, snap_count=1.
REQ-038 The bench SHALL cover x0 and out-of-range writes: rd=0, then rd=20 with NR_REGS=16, each wdata=0x1 -> gpr0=0, shadow file unchanged, two snapshots presented.
REQ-039 The bench SHALL cover backpressure: snap_ready=0 with 5 commits offered, DEPTH=4 -> the first record is presented and held, 4 more are buffered, commit_ready=0 on the 6th offer; releasing snap_ready yields 5 snapshots in order on consecutive cycles, snap_count=5.
REQ-040 The bench SHALL cover flush: 3 records buffered, snapshot pending, flush pulsed -> snap_valid=0 the next cycle, no further snapshots, shadow values of the already-presented record retained, snap_count unchanged.
REQ-041 The bench SHALL cover reset mid-operation: resetn=0 while in PRESENT with FIFO occupancy 2 -> next cycle snap_valid=0, snap_count=0, all GPR outputs 0, and no stale record emitted after reset is released.
REQ-042 The bench SHALL cover counter wrap: snap_count forced or preloaded near 0xFFFFFFFF, then two snapshot handshakes -> the value wraps to 0x00000000 and then 0x00000001.
